// File: rtl/iq_requant_fifo.sv
// Requantizes wide baseband I/Q samples to OUT_W bits (round half up, then clip)
// and buffers them in a show-ahead FIFO with saturation and overflow counters.
module iq_requant_fifo #(
  parameter int IN_W  = 62,
  parameter int OUT_W = 16,
  parameter int SHIFT = 46,
  parameter int DEPTH = 8
) (
  input  logic                     clk16,
  input  logic                     reset,
  input  logic [IN_W-1:0]          sig_demod_30_real,
  input  logic [IN_W-1:0]          sig_demod_30_imag,
  input  logic                     in_valid,
  output logic [OUT_W-1:0]         out_real,
  output logic [OUT_W-1:0]         out_imag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              sat_cnt,
  output logic [15:0]              ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [IN_W:0] MAX_V = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [IN_W:0] MIN_V = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  // Sign-extend by one bit so adding the half-LSB can never overflow.
  function automatic logic [IN_W:0] round_shift(input logic [IN_W-1:0] x);
    logic [IN_W:0]        half;
    logic signed [IN_W:0] sum;
    half          = '0;
    half[SHIFT-1] = 1'b1;
    sum           = $signed({x[IN_W-1], x}) + $signed(half);
    return sum >>> SHIFT;
  endfunction

  // Returns {clipped_flag, value}.
  function automatic logic [OUT_W:0] clip(input logic [IN_W:0] r);
    logic [OUT_W:0] res;
    if ($signed(r) > $signed(MAX_V)) begin
      res = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end else if ($signed(r) < $signed(MIN_V)) begin
      res = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      res = {1'b0, r[OUT_W-1:0]};
    end
    return res;
  endfunction

  logic                s1_valid_q;
  logic [IN_W:0]       s1_re_q, s1_im_q;
  logic [OUT_W-1:0]    mem_re_q [DEPTH];
  logic [OUT_W-1:0]    mem_im_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         level_q, level_d;
  logic [15:0]         sat_cnt_q, sat_cnt_d, ovf_cnt_q, ovf_cnt_d;
  logic [OUT_W:0]      clip_re_s, clip_im_s;
  logic                pop_s, full_s, wr_s, drop_s, sat_hit_s;

  always_ff @(posedge clk16) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_re_q <= round_shift(sig_demod_30_real);
        s1_im_q <= round_shift(sig_demod_30_imag);
      end
    end
  end

  always_comb begin
    clip_re_s = clip(s1_re_q);
    clip_im_s = clip(s1_im_q);
    sat_hit_s = clip_re_s[OUT_W] | clip_im_s[OUT_W];
    pop_s     = (level_q != '0) & out_ready;
    full_s    = (level_q == LVL_FULL);
    // A full FIFO still accepts a write when the head leaves on the same edge.
    wr_s      = s1_valid_q & (~full_s | pop_s);
    drop_s    = s1_valid_q & full_s & ~pop_s;

    wr_ptr_d  = wr_s  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = pop_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({wr_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    if (s1_valid_q && sat_hit_s && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
    if (drop_s && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  always_ff @(posedge clk16) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      sat_cnt_q <= 16'd0;
      ovf_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      sat_cnt_q <= sat_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge clk16) begin
    if (wr_s && !reset) begin
      mem_re_q[wr_ptr_q] <= clip_re_s[OUT_W-1:0];
      mem_im_q[wr_ptr_q] <= clip_im_s[OUT_W-1:0];
    end
  end

  assign out_valid = (level_q != '0);
  assign out_real  = out_valid ? mem_re_q[rd_ptr_q] : '0;
  assign out_imag  = out_valid ? mem_im_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign sat_cnt   = sat_cnt_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_iq_requant_fifo.sv
// Randomized and directed bench for iq_requant_fifo against a queue-based model.
module tb_iq_requant_fifo;
  localparam int IN_W  = 62;
  localparam int OUT_W = 16;
  localparam int SHIFT = 46;
  localparam int DEPTH = 8;

  logic              clk16 = 1'b0;
  logic              reset;
  logic [IN_W-1:0]   sig_re, sig_im;
  logic              in_valid, out_ready;
  logic [OUT_W-1:0]  out_real, out_imag;
  logic              out_valid;
  logic [3:0]        level;
  logic [15:0]       sat_cnt, ovf_cnt;

  always #5 clk16 = ~clk16;

  iq_requant_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk16(clk16), .reset(reset),
    .sig_demod_30_real(sig_re), .sig_demod_30_imag(sig_im),
    .in_valid(in_valid), .out_real(out_real), .out_imag(out_imag),
    .out_valid(out_valid), .out_ready(out_ready), .level(level),
    .sat_cnt(sat_cnt), .ovf_cnt(ovf_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model: a one-deep pending slot plus a bounded queue.
  longint q_re[$], q_im[$];
  bit     pend_v = 1'b0;
  bit     pend_sat;
  longint pend_re, pend_im;
  longint m_sat = 0, m_ovf = 0;

  function automatic longint requant(input logic [IN_W-1:0] x);
    longint v, d, y;
    v = $signed(x);
    d = longint'(1) << SHIFT;
    y = v + d / 2;
    if (y >= 0) return y / d;
    else return -((-y + d - 1) / d);
  endfunction

  function automatic longint clip16(input longint r);
    if (r > 32767) return 32767;
    else if (r < -32768) return -32768;
    else return r;
  endfunction

  function automatic logic [IN_W-1:0] mk(input longint k, input longint off);
    longint t;
    t = k * (longint'(1) << SHIFT) + off;
    return t[IN_W-1:0];
  endfunction

  function automatic logic [IN_W-1:0] rnd_word();
    logic [63:0] w;
    longint      k, off;
    off = (longint'($urandom_range(0, 16383)) << 32) | longint'($urandom());
    case ($urandom_range(0, 3))
      0: begin w = {$urandom(), $urandom()}; return w[IN_W-1:0]; end
      1: begin k = longint'($urandom_range(0, 65535)) - 32768; return mk(k, off); end
      2: begin k = longint'($urandom_range(32760, 32767)); return mk(k, off); end
      3: begin
        k = longint'($urandom_range(0, 65535)) - 32768;
        return mk(k, (longint'(1) << (SHIFT-1)) - longint'($urandom_range(0, 1)));
      end
      default: return '0;
    endcase
  endfunction

  task automatic cycle(input bit rst, input bit v, input logic [IN_W-1:0] re,
                       input logic [IN_W-1:0] im, input bit rdy, input bit en);
    bit     popm;
    longint r_re, r_im;
    reset = rst; in_valid = v; sig_re = re; sig_im = im; out_ready = rdy;
    if (rst) begin
      q_re.delete(); q_im.delete();
      pend_v = 1'b0; m_sat = 0; m_ovf = 0;
    end else begin
      popm = (q_re.size() != 0) && rdy;
      if (pend_v && pend_sat && m_sat < 65535) m_sat++;
      if (popm) begin
        void'(q_re.pop_front());
        void'(q_im.pop_front());
      end
      if (pend_v) begin
        if (q_re.size() < DEPTH) begin
          q_re.push_back(pend_re);
          q_im.push_back(pend_im);
        end else begin
          if (m_ovf < 65535) m_ovf++;
        end
      end
      pend_v = v;
      if (v) begin
        r_re = requant(re);
        r_im = requant(im);
        pend_re  = clip16(r_re);
        pend_im  = clip16(r_im);
        pend_sat = (r_re != pend_re) || (r_im != pend_im);
      end
    end
    @(posedge clk16);
    @(negedge clk16);
    if (en) begin
      chk("level", longint'(level), longint'(q_re.size()));
      chk("out_valid", longint'(out_valid), longint'(q_re.size() != 0));
      if (q_re.size() != 0) begin
        chk("out_real", longint'($signed(out_real)), q_re[0]);
        chk("out_imag", longint'($signed(out_imag)), q_im[0]);
      end
      chk("sat_cnt", longint'(sat_cnt), m_sat);
      chk("ovf_cnt", longint'(ovf_cnt), m_ovf);
    end
  endtask

  logic [IN_W-1:0] junk, big_pos, big_neg;

  initial begin
    junk    = 62'h155_5555_5555_5555;
    big_pos = 62'h1FFF_FFFF_FFFF_FFFF;
    big_neg = 62'h2000_0000_0000_0000;

    // Reset with in_valid high must not admit anything.
    cycle(1'b1, 1'b1, big_pos, big_neg, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, big_pos, big_neg, 1'b1, 1'b1);
    chk("rst_level", longint'(level), 0);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_real", longint'($signed(out_real)), 0);
    chk("rst_imag", longint'($signed(out_imag)), 0);

    // Rounding at a half-LSB tie, two edges of latency.
    cycle(1'b0, 1'b1, mk(100, longint'(1) << 45), mk(-1, longint'(1) << 45), 1'b0, 1'b1);
    chk("lat_not_yet", longint'(out_valid), 0);
    cycle(1'b0, 1'b0, junk, junk, 1'b0, 1'b1);
    chk("round_real", longint'($signed(out_real)), 101);
    chk("round_imag", longint'($signed(out_imag)), 0);
    chk("round_sat", longint'(sat_cnt), 0);
    cycle(1'b0, 1'b0, junk, junk, 1'b1, 1'b1);

    // Extreme inputs clip to the output range.
    cycle(1'b0, 1'b1, big_pos, big_neg, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, junk, junk, 1'b0, 1'b1);
    chk("clip_real", longint'($signed(out_real)), 32767);
    chk("clip_imag", longint'($signed(out_imag)), -32768);
    chk("clip_sat", longint'(sat_cnt), 1);
    cycle(1'b0, 1'b0, junk, junk, 1'b1, 1'b1);

    // Nine pairs into a stalled FIFO: one drop, then in-order drain.
    for (int k = 1; k <= 9; k++) cycle(1'b0, 1'b1, mk(k, 0), mk(-k, 0), 1'b0, 1'b1);
    cycle(1'b0, 1'b0, junk, junk, 1'b0, 1'b1);
    chk("full_level", longint'(level), 8);
    chk("full_ovf", longint'(ovf_cnt), 1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", longint'($signed(out_real)), i);
      cycle(1'b0, 1'b0, junk, junk, 1'b1, 1'b1);
    end
    chk("drain_empty", longint'(out_valid), 0);

    // Full FIFO streaming: write and pop together keep it at DEPTH.
    for (int k = 1; k <= 9; k++) cycle(1'b0, 1'b1, mk(k + 10, 0), mk(k, 0), 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b1, mk(k + 100, 0), mk(-k, 0), 1'b1, 1'b1);
      chk("stream_level", longint'(level), 8);
      chk("stream_ovf", longint'(ovf_cnt), 1);
    end
    for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0, junk, junk, 1'b1, 1'b1);

    // Reset with data stored and a pair in flight.
    for (int k = 1; k <= 6; k++) cycle(1'b0, 1'b1, big_pos, mk(k, 0), 1'b0, 1'b1);
    chk("pre_rst_level", longint'(level), 5);
    cycle(1'b1, 1'b1, junk, junk, 1'b1, 1'b1);
    chk("mid_rst_level", longint'(level), 0);
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_sat", longint'(sat_cnt), 0);
    chk("mid_rst_ovf", longint'(ovf_cnt), 0);
    cycle(1'b0, 1'b0, junk, junk, 1'b0, 1'b1);
    chk("no_stray_write", longint'(level), 0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            rnd_word(), rnd_word(), ($urandom_range(0, 2) == 0), 1'b1);
    end

    // Counter saturation: drive clipping pairs into a stalled FIFO.
    cycle(1'b1, 1'b0, junk, junk, 1'b0, 1'b1);
    for (int n = 0; n < 70000 && m_ovf < 65534; n++) begin
      cycle(1'b0, 1'b1, big_pos, big_neg, 1'b0, 1'b0);
    end
    chk("ovf_fffe", longint'(ovf_cnt), 65534);
    for (int n = 0; n < 3; n++) cycle(1'b0, 1'b1, big_pos, big_neg, 1'b0, 1'b1);
    chk("ovf_ffff", longint'(ovf_cnt), 65535);
    for (int n = 0; n < 2; n++) cycle(1'b0, 1'b1, big_pos, big_neg, 1'b0, 1'b1);
    chk("ovf_hold", longint'(ovf_cnt), 65535);
    chk("sat_hold", longint'(sat_cnt), 65535);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
